// File: rtl/memory_arbiter_if.sv
// memory_arbiter_if: request/grant and per-CU memory bus between CUs and the arbiter
interface memory_arbiter_if #(
  parameter int num_cu = 4,
  parameter int num_cu_log = 2,
  parameter int memory_size_log = 10
);
  logic [num_cu-1:0] i_Grant_Request;
  logic [num_cu-1:0] o_Grant;
  logic [num_cu-1:0] i_Memory_Read_Enable;
  logic [num_cu-1:0] i_Memory_Write_Enable;
  logic [num_cu*memory_size_log-1:0] i_Memory_Address;
  logic o_Memory_Read_Enable;
  logic o_Memory_Write_Enable;
  logic [memory_size_log-1:0] o_Memory_Address;
  logic [num_cu_log-1:0] o_Owner;
  logic o_Busy;
  logic o_Timeout;
  modport master (
    output i_Grant_Request, i_Memory_Read_Enable, i_Memory_Write_Enable, i_Memory_Address,
    input o_Grant, o_Memory_Read_Enable, o_Memory_Write_Enable, o_Memory_Address, o_Owner, o_Busy, o_Timeout
  );
  modport slave (
    input i_Grant_Request, i_Memory_Read_Enable, i_Memory_Write_Enable, i_Memory_Address,
    output o_Grant, o_Memory_Read_Enable, o_Memory_Write_Enable, o_Memory_Address, o_Owner, o_Busy, o_Timeout
  );
endinterface

// File: rtl/memory_arbiter.sv
// memory_arbiter: round-robin single-owner memory arbiter with a dead cycle after each release; ARB_HOLD_LIMIT_EN adds a sticky hold-limit timeout
module memory_arbiter #(
  parameter int num_cu = 4,
  parameter int num_cu_log = 2,
  parameter int memory_size_log = 10,
  parameter int max_hold = 16
) (
  input logic i_Clock,
  input logic i_Reset,
  memory_arbiter_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_GRANTED, S_RELEASE} state_t;
  state_t state_q, state_d;
  logic [num_cu-1:0] grant_q, grant_d;
  logic [num_cu_log-1:0] owner_q, owner_d, ptr_q, ptr_d, off, win;
  logic busy_q, busy_d, hit, granted;
  logic [2*num_cu-1:0] dbl;
  logic [num_cu-1:0] rot;
  logic [num_cu_log:0] sum;
  // rotate requests so the pointer sits at bit 0; lowest set bit is the winner
  always_comb begin
    dbl = {bus.i_Grant_Request, bus.i_Grant_Request} >> ptr_q;
    rot = dbl[num_cu-1:0];
    hit = 1'b0;
    off = '0;
    for (int i = num_cu - 1; i >= 0; i--) begin
      if (rot[i]) begin
        hit = 1'b1;
        off = num_cu_log'(i);
      end
    end
    sum = {1'b0, ptr_q} + {1'b0, off};
    win = num_cu_log'(sum >= (num_cu_log+1)'(num_cu) ? sum - (num_cu_log+1)'(num_cu) : sum);
  end
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
    busy_d = busy_q;
    ptr_d = ptr_q;
    case (state_q)
      S_IDLE: begin
        grant_d = hit ? num_cu'(1) << win : '0;
        owner_d = hit ? win : owner_q;
        busy_d = hit;
        state_d = hit ? S_GRANTED : S_IDLE;
      end
      S_GRANTED: begin
        if (!bus.i_Grant_Request[owner_q]) begin
          state_d = S_RELEASE;
          grant_d = '0;
          busy_d = 1'b0;
          ptr_d = owner_q == num_cu_log'(num_cu - 1) ? '0 : owner_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge i_Clock) begin
    if (!i_Reset) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      owner_q <= '0;
      busy_q <= 1'b0;
      ptr_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      busy_q <= busy_d;
      ptr_q <= ptr_d;
    end
  end
`ifdef ARB_HOLD_LIMIT_EN
  localparam int HW = $clog2(max_hold + 2);
  logic [HW-1:0] hold_q, hold_d;
  logic timeout_q, timeout_d;
  // counter saturates just past the limit; the flag is sticky so nothing beyond matters
  always_comb begin
    hold_d = state_d != S_GRANTED ? '0 : hold_q == HW'(max_hold + 1) ? hold_q : hold_q + 1'b1;
    timeout_d = timeout_q | (hold_d > HW'(max_hold));
  end
  always_ff @(posedge i_Clock) begin
    if (!i_Reset) begin
      hold_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      hold_q <= hold_d;
      timeout_q <= timeout_d;
    end
  end
  assign bus.o_Timeout = timeout_q;
`else
  assign bus.o_Timeout = 1'b0;
`endif
  assign granted = state_q == S_GRANTED;
  assign bus.o_Grant = grant_q;
  assign bus.o_Owner = owner_q;
  assign bus.o_Busy = busy_q;
  assign bus.o_Memory_Read_Enable = granted & bus.i_Memory_Read_Enable[owner_q];
  assign bus.o_Memory_Write_Enable = granted & bus.i_Memory_Write_Enable[owner_q];
  assign bus.o_Memory_Address = granted ? bus.i_Memory_Address[owner_q*memory_size_log +: memory_size_log] : '0;
endmodule

// File: doc/memory_arbiter.md
MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 Parameter num_cu, default 4, number of requesting CUs.
REQ-002 Parameter num_cu_log, default 2, width of owner index.
REQ-003 Parameter memory_size_log, default 10, memory address width.
REQ-004 Parameter max_hold, default 16, hold-limit threshold in cycles.
REQ-005 i_Clock  input  1  sole clock, all state updates on rising edge.
REQ-006 i_Reset  input  1  reset; synchronous, active-low.
REQ-007 i_Grant_Request  input  num_cu  bit n = CU n grant request.
REQ-008 o_Grant  output  num_cu  one-hot or zero; bit n grants CU n.
REQ-009 i_Memory_Read_Enable  input  num_cu  per-CU memory read enable.
REQ-010 i_Memory_Write_Enable  input  num_cu  per-CU memory write enable.
REQ-011 i_Memory_Address  input  num_cu*memory_size_log  packed; CU n at bits [n*memory_size_log +: memory_size_log].
REQ-012 o_Memory_Read_Enable  output  1  shared memory read enable.
REQ-013 o_Memory_Write_Enable  output  1  shared memory write enable.
REQ-014 o_Memory_Address  output  memory_size_log  shared memory address.
REQ-015 o_Owner  output  num_cu_log  index of granted CU; valid when o_Busy=1.
REQ-016 o_Busy  output  1  high while a grant is held.
REQ-017 o_Timeout  output  1  sticky hold-limit violation flag.

Function
REQ-018 States SHALL be S_IDLE, S_GRANTED, S_RELEASE; o_Grant, o_Owner, o_Busy registered.
REQ-019 S_IDLE: if any i_Grant_Request bit set, select first set bit at or above r_Pointer, wrapping modulo num_cu; next edge: o_Grant one-hot for winner, o_Owner=winner, o_Busy=1, go S_GRANTED.
REQ-020 S_IDLE with no request: remain, o_Grant=0.
REQ-021 S_GRANTED: hold grant unchanged while owner's request bit is 1; other requests ignored.
REQ-022 S_GRANTED with owner request 0 at edge: o_Grant=0, o_Busy=0, r_Pointer=(owner+1) mod num_cu, go S_RELEASE.
REQ-023 S_RELEASE: one dead cycle, no grant, requests ignored; next edge go S_IDLE.
REQ-024 Grant latency: request sampled in S_IDLE at edge t yields o_Grant at edge t+1; minimum gap between consecutive grants is 2 cycles.
REQ-025 Memory mux combinational: in S_GRANTED, o_Memory_* = owner's inputs; otherwise all 0.
REQ-026 Non-owner memory enables SHALL never reach outputs.
REQ-027 Owner request dropping on the cycle grant is issued: S_GRANTED lasts exactly one cycle, then S_RELEASE.
REQ-028 r_Pointer wraps from num_cu-1 to 0.

Reset
REQ-029 i_Reset=0 at rising edge: state S_IDLE, o_Grant=0, o_Owner=0, o_Busy=0, r_Pointer=0, hold counter=0, o_Timeout=0.
REQ-030 Reset mid-grant SHALL drop the grant at that edge; no arbitration that cycle.

Configuration
REQ-031 Macro ARB_HOLD_LIMIT_EN defined: counter counts S_GRANTED cycles from 1, clears on leaving; when count exceeds max_hold, o_Timeout=1 until reset; grant NOT revoked.
REQ-032 ARB_HOLD_LIMIT_EN undefined: no counter, o_Timeout constant 0; other behaviour identical.

Verification
REQ-033 Reset held 2 cycles with requests 4'b1111 -> o_Grant=0, o_Busy=0, o_Owner=0, memory outputs 0.
REQ-034 Idle, CU2 requests, address 10'h155, read enable 1 -> next edge o_Grant=4'b0100, o_Owner=2, o_Memory_Address=10'h155, o_Memory_Read_Enable=1.
REQ-035 Pointer 0, requests 4'b1011 held until granted, each owner holds 3 cycles -> grants CU0, CU1, CU3 in order, one dead cycle between.
REQ-036 CU0 re-requests immediately after release while CU1 pending -> CU1 granted next, then CU0.
REQ-037 Reset asserted while CU3 granted -> o_Grant=0 at that edge; subsequent request 4'b1000 granted after reset release.
REQ-038 ARB_HOLD_LIMIT_EN, max_hold=16, owner holds 17 cycles -> o_Timeout=1 and stays 1 after release; macro undefined -> o_Timeout=0.
